// File: rtl/beat_pkg.sv
// Shared types and constants for the tempo beat generator.
package beat_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } beat_state_e;

  localparam int DEFAULT_PERIOD_C = 1000;
  localparam int DEFAULT_BPB_C    = 4;

  // Zero is never a legal period or bar length; it means "one".
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/beat_period_counter.sv
// Ticks-per-beat counter: counts qualified ticks, flags the terminal count
// and wraps to zero there.
module beat_period_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] q_q, q_d;

  assign tc = (q_q == limit - W'(1));

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (adv) q_d = tc ? '0 : q_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/tempo_beat_generator.sv
// Tempo beat generator: start/stop FSM, deferred period handshake and bar
// tracking around beat_period_counter. Optional swing via TEMPO_SWING_EN.
module tempo_beat_generator
  import beat_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_C,
  parameter int BAR_W          = 4,
  parameter int DEFAULT_BPB    = DEFAULT_BPB_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ci,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_valid,
  output logic             period_ready,
  input  logic [BAR_W-1:0] beats_per_bar,
`ifdef TEMPO_SWING_EN
  input  logic             swing_on,
`endif
  output logic             co,
  output logic             bar_co,
  output logic [BAR_W-1:0] beat_idx,
  output logic             running
);

`ifdef TEMPO_SWING_EN
  localparam int QW = CNT_W + 1;
`else
  localparam int QW = CNT_W;
`endif

  beat_state_e      state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [BAR_W-1:0] beat_idx_q, beat_idx_d;
  logic [BAR_W-1:0] bpb_q, bpb_d;

  logic [CNT_W-1:0] period_in_cl;
  logic [QW-1:0]    limit;
  logic             xfer, go, stop_load, tc, last_beat;

  assign running      = (state_q == RUNNING);
  assign period_ready = !pend_valid_q;
  assign xfer         = period_valid && period_ready;
  assign period_in_cl = CNT_W'(clamp_to_one(32'(period_in)));
  assign go           = (state_q == STOPPED) && start && !stop;
  assign last_beat    = (beat_idx_q == bpb_q - BAR_W'(1));
  assign co           = running && ci && tc;
  assign bar_co       = co && last_beat;
  assign beat_idx     = beat_idx_q;

`ifdef TEMPO_SWING_EN
  logic [QW-1:0] per_ext, quarter;
  assign per_ext = {1'b0, period_q};
  assign quarter = per_ext >> 2;
  // Even beats are stretched, odd beats shortened by a quarter period.
  assign limit   = !swing_on      ? per_ext :
                   beat_idx_q[0]  ? per_ext - quarter : per_ext + quarter;
`else
  assign limit   = period_q;
`endif

  beat_period_counter #(.W(QW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .adv   (running && ci),
    .clr   (go || stop_load),
    .limit (limit),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (start && !stop) state_d = RUNNING;
      RUNNING: if (stop)           state_d = STOPPED;
      default:                     state_d = STOPPED;
    endcase
  end

  // A transfer in the same cycle as a beat lands in pend and waits for the
  // following beat, because pend is only consumed from its old contents.
  always_comb begin
    period_d     = period_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    stop_load    = 1'b0;
    if (running) begin
      if (co && pend_valid_q) begin
        period_d     = pend_q;
        pend_valid_d = 1'b0;
      end
      if (xfer) begin
        pend_d       = period_in_cl;
        pend_valid_d = 1'b1;
      end
    end else if (pend_valid_q) begin
      period_d     = pend_q;
      pend_valid_d = 1'b0;
      stop_load    = 1'b1;
    end else if (xfer) begin
      period_d  = period_in_cl;
      stop_load = 1'b1;
    end
  end

  always_comb begin
    beat_idx_d = beat_idx_q;
    bpb_d      = bpb_q;
    if (go) begin
      beat_idx_d = '0;
    end else if (co) begin
      if (last_beat) begin
        beat_idx_d = '0;
        bpb_d      = BAR_W'(clamp_to_one(32'(beats_per_bar)));
      end else begin
        beat_idx_d = beat_idx_q + BAR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= STOPPED;
      period_q     <= CNT_W'(DEFAULT_PERIOD);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      beat_idx_q   <= '0;
      bpb_q        <= BAR_W'(DEFAULT_BPB);
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      beat_idx_q   <= beat_idx_d;
      bpb_q        <= bpb_d;
    end
  end

endmodule

// File: tb/tb_tempo_beat_generator.sv
// Bench for tempo_beat_generator: countdown-based reference model checked
// every cycle, plus directed literal expectations per scenario.
module tb_tempo_beat_generator;
  localparam int CNT_W = 8;
  localparam int DP    = 4;
  localparam int BAR_W = 4;
  localparam int DBPB  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ci = 1'b0, start = 1'b0, stop = 1'b0, period_valid = 1'b0;
  logic [CNT_W-1:0] period_in = '0;
  logic [BAR_W-1:0] beats_per_bar = 4'd4;
  logic             period_ready, co, bar_co, running;
  logic [BAR_W-1:0] beat_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tempo_beat_generator #(
    .CNT_W(CNT_W), .DEFAULT_PERIOD(DP), .BAR_W(BAR_W), .DEFAULT_BPB(DBPB)
  ) dut (
    .clk(clk), .rst(rst), .ci(ci), .start(start), .stop(stop),
    .period_in(period_in), .period_valid(period_valid),
    .period_ready(period_ready), .beats_per_bar(beats_per_bar),
`ifdef TEMPO_SWING_EN
    .swing_on(1'b0),
`endif
    .co(co), .bar_co(bar_co), .beat_idx(beat_idx), .running(running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining ticks in the current beat, absolute bar position.
  bit m_run, m_pend_v;
  int m_left, m_period, m_pend, m_bpb, m_idx;
  bit e_co, e_bar, e_xfer;
  int e_pv;

  always @(negedge clk) begin
    if (rst) begin
      m_run = 0; m_pend_v = 0; m_left = DP; m_period = DP; m_pend = 0;
      m_bpb = DBPB; m_idx = 0;
      check("rst_co", co, 0);
      check("rst_running", running, 0);
      check("rst_ready", period_ready, 1);
    end else begin
      e_co  = m_run && ci && (m_left == 1);
      e_bar = e_co && (m_idx == m_bpb - 1);
      check("mdl_co", co, e_co);
      check("mdl_bar_co", bar_co, e_bar);
      check("mdl_beat_idx", beat_idx, m_idx);
      check("mdl_running", running, m_run);
      check("mdl_ready", period_ready, !m_pend_v);
      e_xfer = period_valid && !m_pend_v;
      e_pv   = (period_in == 0) ? 1 : int'(period_in);
      if (m_run) begin
        if (ci) begin
          if (e_co) begin
            if (m_pend_v) begin m_period = m_pend; m_pend_v = 0; end
            m_left = m_period;
            if (e_bar) begin
              m_idx = 0;
              m_bpb = (beats_per_bar == 0) ? 1 : int'(beats_per_bar);
            end else m_idx = m_idx + 1;
          end else m_left = m_left - 1;
        end
        if (e_xfer) begin m_pend = e_pv; m_pend_v = 1; end
        if (stop) m_run = 0;
      end else begin
        if (m_pend_v) begin m_period = m_pend; m_pend_v = 0; end
        else if (e_xfer) m_period = e_pv;
        if (start && !stop) begin m_run = 1; m_left = m_period; m_idx = 0; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic load_stopped(input logic [CNT_W-1:0] p);
    period_in = p; period_valid = 1'b1; tick(); period_valid = 1'b0;
  endtask

  initial begin
    logic [0:11] ci_pat;
    // Reset state
    tick(); tick();
    check("reset_idx", beat_idx, 0);
    check("reset_bar_co", bar_co, 0);
    rst = 1'b0;
    ci = 1'b1;
    tick();

    // T1: default period 4, free-running ticks
    pulse_start();
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check("t1_co", co, (j % 4) == 0);
      check("t1_bar_co", bar_co, j == 16);
      check("t1_idx", beat_idx, (j - 1) / 4);
      tick();
    end
    @(negedge clk);
    check("t1_idx_wrap", beat_idx, 0);
    tick();

    // T2: period 3, ci alternating
    pulse_stop();
    load_stopped(8'd3);
    pulse_start();
    for (int j = 1; j <= 12; j++) begin
      ci = (j % 2) == 1;
      @(negedge clk);
      check("t2_co", co, (j == 5) || (j == 11));
      tick();
    end
    ci = 1'b1;

    // T3: deferred period update, second request held until ready returns
    pulse_stop();
    load_stopped(8'd5);
    pulse_start();
    for (int j = 1; j <= 15; j++) begin
      period_valid = (j >= 2) && (j <= 6);
      period_in    = (j == 2) ? 8'd2 : 8'd7;
      @(negedge clk);
      check("t3_co", co, (j == 5) || (j == 7) || (j == 14));
      if (j == 2 || j == 6) check("t3_ready_hi", period_ready, 1);
      if ((j >= 3 && j <= 5) || j == 7) check("t3_ready_lo", period_ready, 0);
      tick();
    end
    period_valid = 1'b0;

    // T4: period 0 clamps to 1, bar length 0 clamps to 1
    pulse_stop();
    load_stopped(8'd0);
    beats_per_bar = 4'd0;
    pulse_start();
    ci_pat = 12'b111111011001;
    for (int j = 1; j <= 12; j++) begin
      ci = ci_pat[j-1];
      @(negedge clk);
      check("t4_co_eq_ci", co, ci_pat[j-1]);
      if (j >= 5) begin
        check("t4_bar_eq_ci", bar_co, ci_pat[j-1]);
        check("t4_idx0", beat_idx, 0);
      end
      tick();
    end
    ci = 1'b1;
    beats_per_bar = 4'd4;

    // T5: stop mid-beat, restart 10 cycles later
    pulse_stop();
    load_stopped(8'd4);
    pulse_start();
    tick(); tick();
    stop = 1'b1;
    @(negedge clk);
    check("t5_co_stop_cycle", co, 0);
    tick();
    stop = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("t5_stopped_co", co, 0);
      check("t5_stopped_run", running, 0);
      tick();
    end
    pulse_start();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("t5_restart_co", co, j == 4);
      check("t5_restart_idx", beat_idx, 0);
      tick();
    end

    // T6: asynchronous reset mid-beat with a pending period
    period_in = 8'd9; period_valid = 1'b1;
    tick();
    period_valid = 1'b0;
    @(negedge clk);
    check("t6_pending", period_ready, 0);
    tick(); tick();
    check("t6_pre_rst_co", co, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_co", co, 0);
    check("t6_async_run", running, 0);
    check("t6_async_ready", period_ready, 1);
    check("t6_async_idx", beat_idx, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_ready", period_ready, 1);
    tick();
    pulse_start();
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("t6_default_period_co", co, j == 4);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tempo_beat_generator.md
Name: tempo_beat_generator

Overview:
Parametrised successor to the fixed-period beat divider. Divides an enable-qualified tick stream (ci) by a runtime-programmable period and emits beat pulses, bar pulses and a beat index. Adds start/stop control, a handshaked period update that is deferred to a beat boundary, and a configurable bar length. Sits between the tick prescaler and the note sequencer in the music-player datapath.

Parameters:
CNT_W, 16, width of the period counter and of period_in.
DEFAULT_PERIOD, 1000, period loaded on reset (ticks per beat); must be ≥1 and < 2^CNT_W.
BAR_W, 4, width of beats_per_bar and beat_idx.
DEFAULT_BPB, 4, beats per bar on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ci  in  1  tick enable; the counter advances only when ci=1.
start  in  1  one-cycle request: STOPPED→RUNNING.
stop  in  1  one-cycle request: RUNNING→STOPPED.
period_in  in  CNT_W  new ticks-per-beat value.
period_valid  in  1  period_in is valid.
period_ready  out  1  block can accept a period update.
beats_per_bar  in  BAR_W  bar length; sampled at each bar boundary.
co  out  1  beat pulse, combinational: terminal count && ci && RUNNING.
bar_co  out  1  co on the last beat of a bar.
beat_idx  out  BAR_W  index of the current beat within the bar, 0-based.
running  out  1  1 in RUNNING.

Behaviour:
- Reset (asynchronous): state=STOPPED; q=0; period=DEFAULT_PERIOD; pend_valid=0; beat_idx=0; bpb=DEFAULT_BPB; running=0; period_ready=1; co=0; bar_co=0.
- FSM STOPPED: q and beat_idx hold; co=0. A start pulse moves the FSM to RUNNING on the next edge, with q=0 and beat_idx=0 (a fresh bar).
- FSM RUNNING: on clk with ci=1, q advances; at q==period-1, q wraps to 0. co rises in that cycle (same-cycle with ci, no register).
- stop pulse: RUNNING→STOPPED on the next edge; q and beat_idx freeze.
- start and stop asserted together: stop wins.
- Beat indexing: on each co, beat_idx = (beat_idx == bpb-1) ? 0 : beat_idx+1. bar_co = co && (beat_idx == bpb-1).
- Bar length: bpb reloads from beats_per_bar when bar_co fires. A beats_per_bar value of 0 is treated as 1.
- Period handshake:
  - A transfer occurs when period_valid && period_ready; the value goes to the pending register (pend_valid=1).
  - period_ready = !pend_valid.
  - The pending value takes effect on the next co edge (q→0 and period←pending together), or immediately if the FSM is STOPPED.
  - A transfer on the same cycle as co is applied at the following beat, not at this one.
- Period clamp: a period_in of 0 is stored as 1. A period of 1 gives co=ci on every cycle while RUNNING.
- Arithmetic: all compares are unsigned at CNT_W. q never exceeds period-1.
- Mid-operation reset: every register returns to its reset value at once; any pending period is discarded.

Optional Feature:
TEMPO_SWING_EN
- Defined: adds input swing_on (1 bit). When swing_on=1, even-index beats use period + (period>>2) and odd-index beats use period - (period>>2). Internal widths grow by one bit to keep the long beat from overflowing.
- Undefined: the port is absent and every beat lasts exactly period ticks.

Decomposition:
- Shared package beat_pkg:
  - FSM state typedef {STOPPED, RUNNING}.
  - Default period and bar-length constants.
  - A function clamping 0 to 1.
- One sub-module, beat_period_counter: q register, terminal-count compare, load-on-wrap. The top level holds the FSM, the handshake and bar logic.

Test Plan:
- DEFAULT_PERIOD=4, ci=1 always, start at cycle 2 → co high every 4th cycle. bar_co on every 4th co. beat_idx sequence 0,1,2,3,0.
- ci toggled 1,0,1,0 with period=3 → co only on cycles where ci=1, once every 3 accepted ticks. q holds while ci=0.
- While RUNNING with period=5, load period_in=2 at q=1 → period_ready low until the next co. The beat after that co lasts 2 ticks. A second valid held in the meantime is accepted only after ready returns.
- period_in=0 accepted → stored as 1. co equals ci each cycle.
- stop at q=2, then start 10 cycles later → co=0 while STOPPED. After restart, beat_idx=0 and the first co comes a full period after the restart.
- Assert rst mid-beat with a pending period → all outputs go to reset values at once (asynchronous). After release, period=DEFAULT_PERIOD and period_ready=1.
